// File: rtl/ttt_move_entry.sv
// Button front end for the tic_tac_toe core: sync, debounce, 3x3 cursor,
// and a one-request-at-a-time move handshake with the core's verdict.
module ttt_move_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       invalid_move,
  input  logic [1:0] winner,
  output logic [3:0] move_idx,
  output logic       move_en,
  output logic [3:0] cursor,
  output logic       busy,
  output logic       reject,
  output logic [3:0] accepted_cnt
);

  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  // bit order: 0 left, 1 right, 2 up, 3 down, 4 sel
  logic [4:0]  raw;
  logic [4:0]  s1;
  logic [4:0]  s2;
  logic [4:0]  deb;
  logic [4:0]  prs;
  logic [15:0] cnt [5];

  state_t state;
  state_t state_n;

  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] nr;
  logic [1:0] nc;
  logic [3:0] cursor_n;

  assign raw = {btn_sel, btn_down, btn_up, btn_right, btn_left};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      deb <= '0;
      prs <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 5; i++) begin
        prs[i] <= 1'b0;
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
          prs[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    row = 2'(cursor / 4'd3);
    col = 2'(cursor % 4'd3);
    nr  = row;
    nc  = col;
    priority case (1'b1)
      prs[0]:  nc = (col == 2'd0) ? 2'd2 : col - 2'd1;
      prs[1]:  nc = (col == 2'd2) ? 2'd0 : col + 2'd1;
      prs[2]:  nr = (row == 2'd0) ? 2'd2 : row - 2'd1;
      prs[3]:  nr = (row == 2'd2) ? 2'd0 : row + 2'd1;
      default: ;
    endcase
    cursor_n = {2'b00, nr} * 4'd3 + {2'b00, nc};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (prs[4] && winner == 2'd0) state_n = ISSUE;
      ISSUE:   state_n = CHECK;
      CHECK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == ISSUE) || (state == CHECK);

  // presses seen outside IDLE fall through untouched, i.e. are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      cursor       <= 4'd4;
      move_idx     <= '0;
      move_en      <= 1'b0;
      reject       <= 1'b0;
      accepted_cnt <= '0;
    end else begin
      move_en <= 1'b0;
      reject  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (prs[4]) begin
            if (winner == 2'd0) begin
              move_idx <= cursor;
              move_en  <= 1'b1;
            end
          end else if (|prs[3:0]) begin
            cursor <= cursor_n;
          end
        end
        CHECK: begin
          if (invalid_move)              reject <= 1'b1;
          else if (accepted_cnt != 4'd9) accepted_cnt <= accepted_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_move_entry.sv
// Directed bench for ttt_move_entry: scoreboarded move requests plus
// cycle-exact checks of latency, cursor wrap, reject and reset paths.
module tb_ttt_move_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left, btn_right, btn_up, btn_down, btn_sel;
  logic       invalid_move;
  logic [1:0] winner;
  logic [3:0] move_idx;
  logic       move_en;
  logic [3:0] cursor;
  logic       busy;
  logic       reject;
  logic [3:0] accepted_cnt;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  ttt_move_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .invalid_move(invalid_move), .winner(winner),
    .move_idx(move_idx), .move_en(move_en), .cursor(cursor),
    .busy(busy), .reject(reject), .accepted_cnt(accepted_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: every move_en must match the next expected cell
  always @(negedge clk) begin
    if (!rst && move_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_move_en", 32'd1, 32'd0);
      end else begin
        chk("move_idx", 32'(move_idx), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_btn(input logic [4:0] m);
    {btn_sel, btn_down, btn_up, btn_right, btn_left} = m;
  endtask

  task automatic release_all();
    set_btn(5'b0);
    wait_n(10);
  endtask

  task automatic press_dir(input logic [4:0] m, input logic [3:0] exp_cur,
                           input string tag);
    set_btn(m);
    wait_n(9);
    chk(tag, 32'(cursor), 32'(exp_cur));
    release_all();
  endtask

  // called at a negedge; checks the request against edge numbering
  task automatic sel_req(input logic [4:0] m, input logic exp_rej,
                         input logic [3:0] exp_acc);
    set_btn(m);
    wait_n(6);
    chk("no_early_move_en", 32'(move_en), 32'd0);
    wait_n(1);
    chk("move_en_t", 32'(move_en), 32'd1);
    chk("busy_t", 32'(busy), 32'd1);
    wait_n(1);
    chk("move_en_t1", 32'(move_en), 32'd0);
    chk("busy_t1", 32'(busy), 32'd1);
    wait_n(1);
    chk("reject_t2", 32'(reject), 32'(exp_rej));
    chk("acc_t2", 32'(accepted_cnt), 32'(exp_acc));
    chk("busy_t2", 32'(busy), 32'd0);
    wait_n(1);
    chk("reject_t3", 32'(reject), 32'd0);
    release_all();
  endtask

  initial begin
    logic moved;
    rst = 1'b1;
    set_btn(5'b0);
    invalid_move = 1'b0;
    winner = 2'd0;
    wait_n(3);
    chk("rst_cursor", 32'(cursor), 32'd4);
    chk("rst_move_en", 32'(move_en), 32'd0);
    chk("rst_move_idx", 32'(move_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    chk("rst_acc", 32'(accepted_cnt), 32'd0);
    rst = 1'b0;
    wait_n(1);

    exp_q.push_back(4'd4);
    sel_req(5'b10000, 1'b0, 4'd1);

    moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_right = ~btn_right;
      wait_n(2);
      if (cursor != 4'd4) moved = 1'b1;
    end
    chk("bounce_no_move", 32'(moved), 32'd0);
    btn_right = 1'b1;
    wait_n(10);
    chk("bounce_hold_move", 32'(cursor), 32'd5);
    wait_n(10);
    chk("held_one_event", 32'(cursor), 32'd5);
    release_all();

    press_dir(5'b00010, 4'd3, "right_wrap");
    press_dir(5'b00100, 4'd0, "up_3_to_0");
    press_dir(5'b00100, 4'd6, "up_0_to_6");
    press_dir(5'b00100, 4'd3, "up_6_to_3");
    press_dir(5'b00100, 4'd0, "up_3_to_0b");
    press_dir(5'b00001, 4'd2, "left_wrap");
    press_dir(5'b01000, 4'd5, "down_2_to_5");
    press_dir(5'b01000, 4'd8, "down_5_to_8");
    press_dir(5'b01000, 4'd2, "down_wrap");

    invalid_move = 1'b1;
    exp_q.push_back(4'd2);
    sel_req(5'b10000, 1'b1, 4'd1);
    invalid_move = 1'b0;

    winner = 2'b01;
    set_btn(5'b10000);
    wait_n(12);
    chk("gameover_busy", 32'(busy), 32'd0);
    chk("gameover_acc", 32'(accepted_cnt), 32'd1);
    release_all();
    press_dir(5'b00010, 4'd0, "gameover_cursor");
    winner = 2'd0;

    exp_q.push_back(4'd0);
    sel_req(5'b10001, 1'b0, 4'd2);
    chk("sel_beats_left", 32'(cursor), 32'd0);

    press_dir(5'b00101, 4'd2, "left_beats_up");

    invalid_move = 1'b1;
    exp_q.push_back(4'd2);
    set_btn(5'b10000);
    wait_n(8);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    set_btn(5'b0);
    wait_n(1);
    chk("rst_check_reject", 32'(reject), 32'd0);
    chk("rst_check_acc", 32'(accepted_cnt), 32'd0);
    chk("rst_check_move_en", 32'(move_en), 32'd0);
    chk("rst_check_busy", 32'(busy), 32'd0);
    chk("rst_check_cursor", 32'(cursor), 32'd4);
    rst = 1'b0;
    invalid_move = 1'b0;
    wait_n(12);
    chk("after_rst_quiet", 32'(accepted_cnt), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
